// File: rtl/pong_game_ctrl_if.sv
// Game-control bundle between the Pong sequencer and the ball/paddle animation logic.
// master drives frame/button/ball events; slave is the sequencer that drives ball control and scores.
interface pong_game_ctrl_if #(
  parameter int SCW = 4,
  parameter int SPW = 4
);
  logic           animate;
  logic           start;
  logic           miss_l;
  logic           miss_r;
  logic           hit;
  logic           ball_rst;
  logic           ball_en;
  logic           serve_dir;
  logic [SPW-1:0] speed;
  logic [SCW-1:0] score_l;
  logic [SCW-1:0] score_r;
  logic           game_over;
  logic [2:0]     state;

  modport master (
    output animate, start, miss_l, miss_r, hit,
    input  ball_rst, ball_en, serve_dir, speed, score_l, score_r, game_over, state
  );

  modport slave (
    input  animate, start, miss_l, miss_r, hit,
    output ball_rst, ball_en, serve_dir, speed, score_l, score_r, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: match state, scores, serve timing and ball speed, all outputs registered.
//  state     | meaning
//  IDLE      | waiting for start press
//  SERVE     | ball centred, counting down serve frames
//  PLAY      | ball moving; hits raise speed, a miss scores a point
//  POINT     | pause after a point, then serve again or end the match
//  GAME_OVER | final scores held until start is pressed
module pong_game_ctrl #(
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_FRAMES  = 60,
  parameter int POINT_FRAMES  = 90,
  parameter int SPEED_INIT    = 3,
  parameter int SPEED_MAX     = 8,
  parameter int HITS_PER_STEP = 4,
  parameter int SCW           = 4,
  parameter int SPW           = 4
) (
  input  logic             clk_pix_i,
  input  logic             rst_n_i,
  pong_game_ctrl_if.slave  bus
);
  localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FCW  = $clog2(MAXF + 1);
  localparam int HCW  = $clog2(HITS_PER_STEP + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  state_e           state_q;
  logic [SCW-1:0]   score_l_q, score_r_q;
  logic [SPW-1:0]   speed_q;
  logic             serve_dir_q, ball_rst_q, ball_en_q, game_over_q, start_q;
  logic [FCW-1:0]   frame_cnt_q;
  logic [HCW-1:0]   hit_cnt_q;

  logic             start_re_d, last_frame_d, win_d;
  logic [SPW-1:0]   speed_d;
  logic [SCW-1:0]   score_l_d, score_r_d;

  assign start_re_d   = bus.start & ~start_q;
  assign last_frame_d = bus.animate && (frame_cnt_q == FCW'(1));
  assign win_d        = (score_l_q == SCW'(WIN_SCORE)) || (score_r_q == SCW'(WIN_SCORE));
  assign speed_d      = (speed_q == SPW'(SPEED_MAX)) ? speed_q : speed_q + SPW'(1);
  // Scores saturate at WIN_SCORE so they can never wrap on the display.
  assign score_l_d    = (score_l_q == SCW'(WIN_SCORE)) ? score_l_q : score_l_q + SCW'(1);
  assign score_r_d    = (score_r_q == SCW'(WIN_SCORE)) ? score_r_q : score_r_q + SCW'(1);

  always_ff @(posedge clk_pix_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      speed_q     <= SPW'(SPEED_INIT);
      serve_dir_q <= 1'b0;
      ball_rst_q  <= 1'b0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
      frame_cnt_q <= '0;
      hit_cnt_q   <= '0;
      start_q     <= 1'b1;
    end else begin
      start_q    <= bus.start;
      ball_rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_re_d) begin
            state_q     <= SERVE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            speed_q     <= SPW'(SPEED_INIT);
            serve_dir_q <= 1'b0;
            hit_cnt_q   <= '0;
            frame_cnt_q <= FCW'(SERVE_FRAMES);
            ball_rst_q  <= 1'b1;
          end
        end
        SERVE: begin
          if (bus.animate) begin
            frame_cnt_q <= frame_cnt_q - FCW'(1);
            if (last_frame_d) begin
              state_q   <= PLAY;
              ball_en_q <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (bus.miss_l || bus.miss_r) begin
            if (bus.miss_l && !bus.miss_r) begin
              score_r_q   <= score_r_d;
              serve_dir_q <= 1'b1;
            end else if (bus.miss_r && !bus.miss_l) begin
              score_l_q   <= score_l_d;
              serve_dir_q <= 1'b0;
            end
            state_q     <= POINT;
            ball_en_q   <= 1'b0;
            frame_cnt_q <= FCW'(POINT_FRAMES);
          end else if (bus.hit) begin
            if (hit_cnt_q == HCW'(HITS_PER_STEP - 1)) begin
              hit_cnt_q <= '0;
              speed_q   <= speed_d;
            end else begin
              hit_cnt_q <= hit_cnt_q + HCW'(1);
            end
          end
        end
        POINT: begin
          if (bus.animate) begin
            frame_cnt_q <= frame_cnt_q - FCW'(1);
            if (last_frame_d) begin
              if (win_d) begin
                state_q     <= GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q     <= SERVE;
                speed_q     <= SPW'(SPEED_INIT);
                hit_cnt_q   <= '0;
                frame_cnt_q <= FCW'(SERVE_FRAMES);
                ball_rst_q  <= 1'b1;
              end
            end
          end
        end
        GAME_OVER: begin
          if (start_re_d) begin
            state_q     <= IDLE;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.speed     = speed_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.ball_en   = ball_en_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: expectations are queued as stimulus is applied and
// compared against the registered outputs one cycle later.
module tb_pong_game_ctrl;
  localparam int SCW = 4;
  localparam int SPW = 4;

  localparam int F_STATE = 0;
  localparam int F_EN    = 1;
  localparam int F_RST   = 2;
  localparam int F_DIR   = 3;
  localparam int F_SPD   = 4;
  localparam int F_SL    = 5;
  localparam int F_SR    = 6;
  localparam int F_GO    = 7;

  typedef struct {
    string      tag;
    int         fld;
    logic [7:0] exp;
  } exp_t;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  pong_game_ctrl_if #(.SCW(SCW), .SPW(SPW)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(2), .SPEED_INIT(3),
    .SPEED_MAX(5), .HITS_PER_STEP(2), .SCW(SCW), .SPW(SPW)
  ) dut (
    .clk_pix_i(clk_pix),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic logic [7:0] obs(int f);
    case (f)
      F_STATE: obs = 8'(bus.state);
      F_EN:    obs = 8'(bus.ball_en);
      F_RST:   obs = 8'(bus.ball_rst);
      F_DIR:   obs = 8'(bus.serve_dir);
      F_SPD:   obs = 8'(bus.speed);
      F_SL:    obs = 8'(bus.score_l);
      F_SR:    obs = 8'(bus.score_r);
      F_GO:    obs = 8'(bus.game_over);
      default: obs = 8'hxx;
    endcase
  endfunction

  task automatic push(string tag, int f, int v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.exp = 8'(v);
    sb.push_back(e);
  endtask

  task automatic exp_ctl(string tag, int st, int en, int br, int go);
    push({tag, ".state"}, F_STATE, st);
    push({tag, ".ball_en"}, F_EN, en);
    push({tag, ".ball_rst"}, F_RST, br);
    push({tag, ".game_over"}, F_GO, go);
  endtask

  task automatic exp_score(string tag, int sl, int sr, int dir);
    push({tag, ".score_l"}, F_SL, sl);
    push({tag, ".score_r"}, F_SR, sr);
    push({tag, ".serve_dir"}, F_DIR, dir);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.fld);
      n_total++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
    end
  endtask

  // Advance one clock edge and sample 1ns later, clear of the edge.
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse_animate();
    bus.animate = 1'b1; tick(); bus.animate = 1'b0;
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1; tick(); bus.hit = 1'b0;
  endtask

  task automatic pulse_miss(logic l, logic r, logic h);
    bus.miss_l = l; bus.miss_r = r; bus.hit = h;
    tick();
    bus.miss_l = 1'b0; bus.miss_r = 1'b0; bus.hit = 1'b0;
  endtask

  task automatic press_start();
    bus.start = 1'b0; tick();
    bus.start = 1'b1; tick();
  endtask

  // SERVE -> PLAY after two animates.
  task automatic serve_to_play(string tag);
    pulse_animate();
    exp_ctl({tag, ".serve1"}, 1, 0, 0, 0); check();
    pulse_animate();
    exp_ctl({tag, ".play"}, 2, 1, 0, 0); check();
  endtask

  // POINT -> SERVE after two animates, with a fresh serve speed.
  task automatic point_to_serve(string tag);
    pulse_animate();
    exp_ctl({tag, ".point1"}, 3, 0, 0, 0); check();
    pulse_animate();
    exp_ctl({tag, ".serve"}, 1, 0, 1, 0);
    push({tag, ".speed"}, F_SPD, 3); check();
  endtask

  initial begin
    bus.animate = 1'b0; bus.start = 1'b1;
    bus.miss_l = 1'b0; bus.miss_r = 1'b0; bus.hit = 1'b0;

    // 1. Reset with start held, stays idle; then start -> serve -> play.
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
    exp_ctl("reset", 0, 0, 0, 0); exp_score("reset", 0, 0, 0);
    push("reset.speed", F_SPD, 3); check();
    tick(); tick(); tick();
    exp_ctl("held_start", 0, 0, 0, 0); check();
    press_start();
    exp_ctl("start", 1, 0, 1, 0); exp_score("start", 0, 0, 0);
    push("start.speed", F_SPD, 3); check();
    tick();
    exp_ctl("serve_hold", 1, 0, 0, 0); check();
    serve_to_play("t1");

    // 2. Hits raise speed every second hit, saturating at 5.
    for (int i = 0; i < 6; i++) begin
      push($sformatf("hit_pre%0d.speed", i), F_SPD, 3 + (i / 2)); check();
      pulse_hit(); tick();
    end
    push("hit_post.speed", F_SPD, 5); check();
    pulse_miss(1'b0, 1'b1, 1'b0);
    exp_ctl("t2.miss_r", 3, 0, 0, 0); exp_score("t2.miss_r", 1, 0, 0); check();
    pulse_hit();
    push("point_hit_ignored.speed", F_SPD, 5); check();
    point_to_serve("t2");
    tick();
    exp_ctl("t2.serve_hold", 1, 0, 0, 0); check();
    serve_to_play("t2");

    // 3. miss_l scores for the right player and flips the serve.
    pulse_miss(1'b1, 1'b0, 1'b0);
    exp_ctl("t3.miss_l", 3, 0, 0, 0); exp_score("t3.miss_l", 1, 1, 1); check();
    point_to_serve("t3");
    tick();
    exp_ctl("t3.one_pulse", 1, 0, 0, 0); check();
    serve_to_play("t3");

    // 4. Double miss with a hit: no score, serve unchanged, hit dropped.
    pulse_hit();
    push("t4.hit1.speed", F_SPD, 3); check();
    pulse_miss(1'b1, 1'b1, 1'b1);
    exp_ctl("t4.double", 3, 0, 0, 0); exp_score("t4.double", 1, 1, 1);
    push("t4.double.speed", F_SPD, 3); check();
    point_to_serve("t4");
    serve_to_play("t4");

    // 5. Right player misses twice more -> left wins.
    pulse_miss(1'b0, 1'b1, 1'b0);
    exp_score("t5.m2", 2, 1, 0); check();
    point_to_serve("t5a");
    serve_to_play("t5a");
    pulse_miss(1'b0, 1'b1, 1'b0);
    exp_score("t5.m3", 3, 1, 0); check();
    pulse_animate(); pulse_animate();
    exp_ctl("t5.game_over", 4, 0, 0, 1); check();
    pulse_miss(1'b1, 1'b1, 1'b1);
    pulse_animate(); tick();
    exp_ctl("t5.go_ignore", 4, 0, 0, 1); exp_score("t5.go_ignore", 3, 1, 0); check();
    press_start();
    exp_ctl("t5.idle", 0, 0, 0, 0); exp_score("t5.idle", 3, 1, 0); check();
    press_start();
    exp_ctl("t5.restart", 1, 0, 1, 0); exp_score("t5.restart", 0, 0, 0); check();
    serve_to_play("t5b");

    // 6. Reach score_l=2, speed=4 in play, then reset mid-play.
    pulse_miss(1'b0, 1'b1, 1'b0);
    point_to_serve("t6a"); serve_to_play("t6a");
    pulse_miss(1'b0, 1'b1, 1'b0);
    point_to_serve("t6b"); serve_to_play("t6b");
    pulse_hit(); pulse_hit();
    push("t6.pre.speed", F_SPD, 4); push("t6.pre.score_l", F_SL, 2);
    push("t6.pre.state", F_STATE, 2); check();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_ctl("t6.reset", 0, 0, 0, 0); exp_score("t6.reset", 0, 0, 0);
    push("t6.reset.speed", F_SPD, 3); check();
    tick();
    exp_ctl("t6.after", 0, 0, 0, 0); check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
